// File: rtl/sram_cascade_ctrl_if.sv
// Bus interface for sram_cascade_ctrl.
// master drives the request side (cs/we/slice_en/addr/inp/clr).
// slave drives the response side (outp/rvalid/busy).
interface sram_cascade_ctrl_if #(
    parameter int SLICE_W = 4,
    parameter int N_SLICE = 2,
    parameter int BANK_AW = 2,
    parameter int BSEL_W  = 1
);
    localparam int W  = SLICE_W * N_SLICE;
    localparam int AW = BANK_AW + BSEL_W;

    logic               cs;
    logic               we;
    logic [N_SLICE-1:0] slice_en;
    logic [AW-1:0]      addr;
    logic [W-1:0]       inp;
    logic               clr;
    logic [W-1:0]       outp;
    logic               rvalid;
    logic               busy;

    modport master (
        output cs, we, slice_en, addr, inp, clr,
        input  outp, rvalid, busy
    );

    modport slave (
        input  cs, we, slice_en, addr, inp, clr,
        output outp, rvalid, busy
    );
endinterface

// File: rtl/sram_cascade_ctrl.sv
// Cascaded SRAM: N_SLICE horizontal slices x 2^BSEL_W banks of 2^BANK_AW words.
// Self-clearing sweep after reset or on clr, per-slice write enables,
// registered 1-cycle read with a one-cycle rvalid strobe.
// Ports:
//   clk  - system clock, all state on rising edge
//   rst  - synchronous active-high reset (restarts the clear sweep)
//   bus  - slave side of sram_cascade_ctrl_if:
//          cs/we/slice_en/addr/inp/clr in, outp/rvalid/busy out
module sram_cascade_ctrl #(
    parameter int SLICE_W = 4,
    parameter int N_SLICE = 2,
    parameter int BANK_AW = 2,
    parameter int BSEL_W  = 1
) (
    input  logic clk,
    input  logic rst,
    sram_cascade_ctrl_if.slave bus
);
    localparam int W      = SLICE_W * N_SLICE;
    localparam int AW     = BANK_AW + BSEL_W;
    localparam int DEPTH  = 1 << AW;
    localparam int NBANK  = 1 << BSEL_W;
    localparam int BDEPTH = 1 << BANK_AW;
    localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);

    typedef enum logic {S_CLEAR, S_IDLE} state_t;

    state_t         r_state;
    logic [AW:0]    r_cnt;
    logic [W-1:0]   r_outp;
    logic           r_rvalid;
    logic           r_busy;
    logic [W-1:0]   r_mem [NBANK][BDEPTH];

    logic               w_wr_en;
    logic [BSEL_W-1:0]  w_bank;
    logic [BANK_AW-1:0] w_word;
    logic [W-1:0]       w_wdata;
    logic [N_SLICE-1:0] w_mask;
    logic [BSEL_W-1:0]  w_rbank;
    logic [BANK_AW-1:0] w_rword;

    // Bank decode is the address MSBs, word decode the LSBs.
    assign w_rbank = bus.addr[AW-1:BANK_AW];
    assign w_rword = bus.addr[BANK_AW-1:0];

    // Single write port shared by the clear sweep and user writes.
    // The sweep owns the port while clearing; clr drops a same-cycle access.
    always_comb begin
        w_wr_en = 1'b0;
        w_bank  = w_rbank;
        w_word  = w_rword;
        w_wdata = bus.inp;
        w_mask  = bus.slice_en;
        if (!rst) begin
            if (r_state == S_CLEAR) begin
                w_wr_en = 1'b1;
                w_bank  = r_cnt[AW-1:BANK_AW];
                w_word  = r_cnt[BANK_AW-1:0];
                w_wdata = '0;
                w_mask  = '1;
            end else if (!bus.clr && bus.cs && bus.we) begin
                w_wr_en = 1'b1;
            end
        end
    end

    // Storage has no reset; the sweep is what zeroes it.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int k = 0; k < N_SLICE; k++) begin
                if (w_mask[k])
                    r_mem[w_bank][w_word][k*SLICE_W +: SLICE_W] <= w_wdata[k*SLICE_W +: SLICE_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_CLEAR;
            r_cnt    <= '0;
            r_outp   <= '0;
            r_rvalid <= 1'b0;
            r_busy   <= 1'b1;
        end else begin
            r_rvalid <= 1'b0;
            case (r_state)
                S_CLEAR: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    if (bus.clr) begin
                        r_state <= S_CLEAR;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end else if (bus.cs && !bus.we) begin
                        r_outp   <= r_mem[w_rbank][w_rword];
                        r_rvalid <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.outp   = r_outp;
    assign bus.rvalid = r_rvalid;
    assign bus.busy   = r_busy;
endmodule

// File: tb/tb_sram_cascade_ctrl.sv
module tb_sram_cascade_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    sram_cascade_ctrl_if #(.SLICE_W(4), .N_SLICE(2), .BANK_AW(2), .BSEL_W(1)) bus ();

    sram_cascade_ctrl #(.SLICE_W(4), .N_SLICE(2), .BANK_AW(2), .BSEL_W(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus();
        bus.cs = 1'b0; bus.we = 1'b0; bus.clr = 1'b0;
        bus.slice_en = 2'b00; bus.addr = '0; bus.inp = '0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d, input logic [1:0] se);
        bus.cs = 1'b1; bus.we = 1'b1; bus.addr = a; bus.inp = d; bus.slice_en = se;
        tick();
        chk("wr_rvalid", {31'd0, bus.rvalid}, 32'd0);
        bus.cs = 1'b0; bus.we = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [2:0] a, input logic [7:0] exp);
        bus.cs = 1'b1; bus.we = 1'b0; bus.addr = a;
        tick();
        chk({tag, "_rvalid"}, {31'd0, bus.rvalid}, 32'd1);
        chk(tag, {24'd0, bus.outp}, {24'd0, exp});
        bus.cs = 1'b0;
    endtask

    // Counts edges until busy falls; a blown bound shows up as a wrong count.
    task automatic busy_edges(output int edges, output int rv_seen);
        edges = 0; rv_seen = 0;
        while (bus.busy === 1'b1 && edges < 40) begin
            bus.we = ~bus.we;
            tick();
            edges++;
            if (bus.rvalid !== 1'b0) rv_seen++;
        end
    endtask

    logic [7:0] vals [8];
    int e, rv;

    initial begin
        idle_bus();

        // 1: reset, sweep length, zeroed memory
        rst = 1'b1;
        tick(); tick();
        chk("rst_busy", {31'd0, bus.busy}, 32'd1);
        chk("rst_rvalid", {31'd0, bus.rvalid}, 32'd0);
        chk("rst_outp", {24'd0, bus.outp}, 32'd0);
        rst = 1'b0;
        busy_edges(e, rv);
        chk("sweep1_edges", e, 32'd8);
        for (int a = 0; a < 8; a++) rd("t1_zero", 3'(a), 8'h00);
        tick();
        chk("t1_rvalid_drop", {31'd0, bus.rvalid}, 32'd0);

        // 2: full-word writes, read back, bank boundary distinct
        for (int a = 0; a < 8; a++) vals[a] = 8'($urandom);
        if (vals[3] == vals[4]) vals[4] = ~vals[3];
        for (int a = 0; a < 8; a++) wr(3'(a), vals[a], 2'b11);
        for (int a = 0; a < 8; a++) rd("t2_rdback", 3'(a), vals[a]);
        // read immediately after write to the same address
        wr(3'd4, 8'h5E, 2'b11);
        rd("t2_raw", 3'd4, 8'h5E);

        // 3: per-slice write enables
        wr(3'd5, 8'h3C, 2'b11);
        wr(3'd5, 8'hAB, 2'b01);
        rd("t3_lo", 3'd5, 8'h3B);
        wr(3'd5, 8'hFF, 2'b00);
        rd("t3_none", 3'd5, 8'h3B);
        wr(3'd5, 8'h9F, 2'b10);
        rd("t3_hi", 3'd5, 8'h9B);
        rd("t3_other", 3'd3, vals[3]);

        // 4: clr with access attempts during busy
        bus.clr = 1'b1;
        tick();
        chk("t4_busy_on", {31'd0, bus.busy}, 32'd1);
        bus.clr = 1'b0;
        bus.cs = 1'b1; bus.we = 1'b1; bus.addr = 3'd2; bus.inp = 8'h55; bus.slice_en = 2'b11;
        busy_edges(e, rv);
        chk("t4_edges", e, 32'd8);
        chk("t4_rvalid_busy", rv, 32'd0);
        idle_bus();
        for (int a = 0; a < 8; a++) rd("t4_zero", 3'(a), 8'h00);

        // 5: reset mid-sweep, then clr beats a same-cycle write
        wr(3'd0, 8'h77, 2'b11);
        rd("t5_pre", 3'd0, 8'h77);
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        chk("t5_rst_outp", {24'd0, bus.outp}, 32'd0);
        chk("t5_rst_rvalid", {31'd0, bus.rvalid}, 32'd0);
        rst = 1'b0;
        busy_edges(e, rv);
        chk("t5_edges", e, 32'd8);
        idle_bus();
        wr(3'd1, 8'h21, 2'b11);
        bus.clr = 1'b1; bus.cs = 1'b1; bus.we = 1'b1; bus.addr = 3'd1;
        bus.inp = 8'h5A; bus.slice_en = 2'b11;
        tick();
        chk("t5_clr_busy", {31'd0, bus.busy}, 32'd1);
        idle_bus();
        busy_edges(e, rv);
        chk("t5_clr_edges", e, 32'd8);
        bus.we = 1'b0;
        rd("t5_a1", 3'd1, 8'h00);

        // 6: outp holds while cs is low
        wr(3'd6, 8'hC4, 2'b11);
        rd("t6_rd", 3'd6, 8'hC4);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_rvalid", {31'd0, bus.rvalid}, 32'd0);
            chk("t6_hold", {24'd0, bus.outp}, 32'h0000_00C4);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
